// File: rtl/axil_reg_responder_pkg.sv
// Shared constants, response codes and FSM state types for the AXI4-Lite register responder.
package axil_reg_responder_pkg;

   localparam logic [3:0] OFF_CTRL    = 4'h0;
   localparam logic [3:0] OFF_ID      = 4'h4;
   localparam logic [3:0] OFF_SCRATCH = 4'h8;
   localparam logic [3:0] OFF_TIMER   = 4'hC;

   localparam logic [31:0] ID_VALUE = 32'h0000_00A5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return res;
   endfunction

endpackage

// File: rtl/axil_wrap_timer.sv
// Free-running 32-bit counter with parallel load; wrap flags the FFFF_FFFF -> 0 step.
module axil_wrap_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [31:0] load_val,
   output logic [31:0] count,
   output logic        wrap
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       count <= '0;
      else if (load) count <= load_val;
      else if (en)   count <= count + 32'd1;
   end

   // A load in the same cycle wins over the wrap.
   assign wrap = en && !load && (count == 32'hFFFF_FFFF);

endmodule

// File: rtl/axil_reg_responder.sv
// AXI4-Lite register block: CTRL, ID, SCRATCH and an optional TIMER at 0xC.
// Define AXIL_TIMER_EN to build the timer in; otherwise 0xC is unmapped and irq is 0.
module axil_reg_responder
   import axil_reg_responder_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic                  sys_clock,
   input  logic                  reset_rtl,
   input  logic [ADDR_W-1:0]     s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [DATA_W-1:0]     s_wdata,
   input  logic [DATA_W/8-1:0]   s_wstrb,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [ADDR_W-1:0]     s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [DATA_W-1:0]     s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic [7:0]            gpio_out,
   output logic                  irq
);

   w_state_t          r_wstate;
   r_state_t          r_rstate;
   logic [DATA_W-1:0] r_ctrl, r_scratch, r_rdata;
   logic [1:0]        r_bresp, r_rresp;
   logic              r_bvalid, r_rvalid;

   logic [1:0]        w_widx, w_ridx;
   logic              w_aw_hs, w_ar_hs, w_timer_map;
   logic [DATA_W-1:0] w_count, w_rd_data;
   logic [1:0]        w_wresp, w_rd_resp;
   logic              w_unused;

   assign w_widx = s_awaddr[3:2];
   assign w_ridx = s_araddr[3:2];
   assign w_unused = &{1'b0, s_awaddr, s_araddr};

   // Readies are gated by reset so nothing handshakes while it is held.
   assign w_aw_hs   = !reset_rtl && (r_wstate == W_IDLE) && s_awvalid && s_wvalid;
   assign s_awready = w_aw_hs;
   assign s_wready  = w_aw_hs;
   assign s_arready = !reset_rtl && (r_rstate == R_IDLE);
   assign w_ar_hs   = s_arready && s_arvalid;

`ifdef AXIL_TIMER_EN
   logic w_timer_wr, w_wrap, r_irq;

   assign w_timer_map = 1'b1;
   assign w_timer_wr  = w_aw_hs && (w_widx == OFF_TIMER[3:2]);

   axil_wrap_timer u_timer (
      .clk      (sys_clock),
      .rst      (reset_rtl),
      .en       (r_ctrl[8]),
      .load     (w_timer_wr),
      .load_val (strb_merge(w_count, s_wdata, s_wstrb)),
      .count    (w_count),
      .wrap     (w_wrap)
   );

   always_ff @(posedge sys_clock or posedge reset_rtl) begin
      if (reset_rtl)       r_irq <= 1'b0;
      else if (w_timer_wr) r_irq <= 1'b0;
      else if (w_wrap)     r_irq <= 1'b1;
   end

   assign irq = r_irq;
`else
   assign w_timer_map = 1'b0;
   assign w_count     = '0;
   assign irq         = 1'b0;
`endif

   always_comb begin
      w_wresp = RESP_OKAY;
      if (w_widx == OFF_ID[3:2])                      w_wresp = RESP_SLVERR;
      if (w_widx == OFF_TIMER[3:2] && !w_timer_map)   w_wresp = RESP_SLVERR;
   end

   always_comb begin
      w_rd_data = '0;
      w_rd_resp = RESP_OKAY;
      case (w_ridx)
         OFF_CTRL[3:2]:    w_rd_data = r_ctrl;
         OFF_ID[3:2]:      w_rd_data = ID_VALUE;
         OFF_SCRATCH[3:2]: w_rd_data = r_scratch;
         default: begin
            if (w_timer_map) w_rd_data = w_count;
            else             w_rd_resp = RESP_SLVERR;
         end
      endcase
   end

   always_ff @(posedge sys_clock or posedge reset_rtl) begin
      if (reset_rtl) begin
         r_wstate  <= W_IDLE;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_ctrl    <= '0;
         r_scratch <= '0;
      end else begin
         case (r_wstate)
            W_IDLE: if (w_aw_hs) begin
               if (w_widx == OFF_CTRL[3:2])    r_ctrl    <= strb_merge(r_ctrl, s_wdata, s_wstrb);
               if (w_widx == OFF_SCRATCH[3:2]) r_scratch <= strb_merge(r_scratch, s_wdata, s_wstrb);
               r_bresp  <= w_wresp;
               r_bvalid <= 1'b1;
               r_wstate <= W_RESP;
            end
            W_RESP: if (s_bready) begin
               r_bvalid <= 1'b0;
               r_bresp  <= RESP_OKAY;
               r_wstate <= W_IDLE;
            end
         endcase
      end
   end

   // Read mux samples pre-edge register values, so a same-cycle write is not seen.
   always_ff @(posedge sys_clock or posedge reset_rtl) begin
      if (reset_rtl) begin
         r_rstate <= R_IDLE;
         r_rvalid <= 1'b0;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: if (w_ar_hs) begin
               r_rdata  <= w_rd_data;
               r_rresp  <= w_rd_resp;
               r_rvalid <= 1'b1;
               r_rstate <= R_DATA;
            end
            R_DATA: if (s_rready) begin
               r_rvalid <= 1'b0;
               r_rstate <= R_IDLE;
            end
         endcase
      end
   end

   assign s_bvalid = r_bvalid;
   assign s_bresp  = r_bresp;
   assign s_rvalid = r_rvalid;
   assign s_rresp  = r_rresp;
   assign s_rdata  = r_rdata;
   assign gpio_out = r_ctrl[7:0];

endmodule

// File: tb/tb_axil_reg_responder.sv
// Directed plus randomized bench for axil_reg_responder with a register-map reference model.
module tb_axil_reg_responder;

   logic        sys_clock = 1'b0;
   logic        reset_rtl = 1'b1;
   logic [3:0]  s_awaddr = '0, s_araddr = '0;
   logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, irq;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata;
   logic [7:0]  gpio_out;

   int checks = 0;
   int errors = 0;
   logic [31:0] model [4];

`ifdef AXIL_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   axil_reg_responder #(.ADDR_W(4), .DATA_W(32)) dut (
      .sys_clock(sys_clock), .reset_rtl(reset_rtl),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .gpio_out(gpio_out), .irq(irq)
   );

   always #5 sys_clock = ~sys_clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk(tag, {31'b0, obs}, {31'b0, exp});
   endtask

   function automatic logic [31:0] ref_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
      logic [31:0] mask = '0;
      for (int b = 0; b < 4; b++) if (strb[b]) mask |= 32'hFF << (8 * b);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   // Register map behaviour in terms of the register index.
   function automatic bit ref_writable(input logic [1:0] idx);
      return idx == 2'd0 || idx == 2'd2 || (idx == 2'd3 && TIMER);
   endfunction

   task automatic ref_read(input logic [1:0] idx, output logic [31:0] d, output logic [1:0] r);
      r = 2'b00;
      case (idx)
         2'd0: d = model[0];
         2'd1: d = 32'h0000_00A5;
         2'd2: d = model[2];
         default: begin d = 32'h0; r = TIMER ? 2'b00 : 2'b10; end
      endcase
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input bit bready_hi, output logic [1:0] resp);
      int n = 0;
      @(negedge sys_clock);
      s_awaddr = addr; s_wdata = data; s_wstrb = strb;
      s_awvalid = 1; s_wvalid = 1; s_bready = bready_hi;
      #1;
      while (!(s_awready && s_wready) && n < 20) begin @(negedge sys_clock); #1; n++; end
      chk1("aw_w_handshake", s_awready && s_wready, 1'b1);
      @(negedge sys_clock);
      s_awvalid = 0; s_wvalid = 0;
      chk1("bvalid_latency", s_bvalid, 1'b1);
      resp = s_bresp;
      if (bready_hi) begin
         @(negedge sys_clock);
         chk1("bvalid_drop", s_bvalid, 1'b0);
      end
   endtask

   task automatic axi_read(input logic [3:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      @(negedge sys_clock);
      s_araddr = addr; s_arvalid = 1; s_rready = 0;
      #1;
      while (!s_arready && n < 20) begin @(negedge sys_clock); #1; n++; end
      chk1("ar_handshake", s_arready, 1'b1);
      @(negedge sys_clock);
      s_arvalid = 0;
      chk1("rvalid_latency", s_rvalid, 1'b1);
      data = s_rdata; resp = s_rresp;
      for (int i = 0; i < hold; i++) begin
         @(negedge sys_clock);
         chk1("rvalid_hold", s_rvalid, 1'b1);
         chk("rdata_hold", s_rdata, data);
         chk("rresp_hold", 32'(s_rresp), 32'(resp));
      end
      s_rready = 1;
      @(negedge sys_clock);
      s_rready = 0;
      chk1("rvalid_drop", s_rvalid, 1'b0);
   endtask

   initial begin
      logic [31:0] d, ed;
      logic [1:0]  r, er, idx;
      logic [3:0]  strb;

      // Reset with every valid asserted: nothing may handshake.
      s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_bready = 1; s_rready = 1;
      repeat (3) @(negedge sys_clock);
      chk1("rst_awready", s_awready, 1'b0);
      chk1("rst_wready", s_wready, 1'b0);
      chk1("rst_arready", s_arready, 1'b0);
      chk1("rst_bvalid", s_bvalid, 1'b0);
      chk1("rst_rvalid", s_rvalid, 1'b0);
      chk("rst_bresp", 32'(s_bresp), 32'd0);
      chk("rst_rresp", 32'(s_rresp), 32'd0);
      chk("rst_rdata", s_rdata, 32'd0);
      chk("rst_gpio", 32'(gpio_out), 32'd0);
      chk1("rst_irq", irq, 1'b0);
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
      reset_rtl = 0;
      for (int i = 0; i < 4; i++) model[i] = '0;

      axi_write(4'h0, 32'h0000_005A, 4'hF, 1, r);
      chk("ctrl_bresp", 32'(r), 32'd0);
      chk("gpio_after_ctrl", 32'(gpio_out), 32'h5A);
      model[0] = 32'h5A;

      axi_read(4'h4, 5, d, r);
      chk("id_rdata", d, 32'hA5);
      chk("id_rresp", 32'(r), 32'd0);

      axi_write(4'h8, 32'hFFFF_FFFF, 4'hF, 1, r);
      axi_write(4'h8, 32'h1234_5678, 4'h3, 1, r);
      model[2] = 32'hFFFF_5678;
      axi_read(4'h8, 0, d, r);
      chk("scratch_strobe", d, 32'hFFFF_5678);
      axi_write(4'h4, 32'hDEAD_BEEF, 4'hF, 1, r);
      chk("id_write_bresp", 32'(r), 32'h2);
      axi_read(4'h4, 0, d, r);
      chk("id_unchanged", d, 32'hA5);

      // Read and write to SCRATCH in the same cycle: read sees the old value.
      @(negedge sys_clock);
      s_awaddr = 4'h8; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'hF;
      s_awvalid = 1; s_wvalid = 1; s_bready = 1;
      s_araddr = 4'h8; s_arvalid = 1; s_rready = 0;
      #1;
      chk1("same_cycle_awready", s_awready, 1'b1);
      chk1("same_cycle_arready", s_arready, 1'b1);
      @(negedge sys_clock);
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      chk1("same_cycle_bvalid", s_bvalid, 1'b1);
      chk1("same_cycle_rvalid", s_rvalid, 1'b1);
      chk("same_cycle_old_data", s_rdata, model[2]);
      s_rready = 1;
      @(negedge sys_clock);
      s_rready = 0;
      model[2] = 32'hCAFE_F00D;
      axi_read(4'h8, 0, d, r);
      chk("same_cycle_new_data", d, model[2]);

      // Randomized traffic against the register-map model.
      for (int k = 0; k < 40; k++) begin
         idx = 2'($urandom_range(0, TIMER ? 2 : 3));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom; strb = 4'($urandom_range(0, 15));
            axi_write({idx, 2'($urandom_range(0, 3))}, d, strb, 1, r);
            chk("rand_bresp", 32'(r), ref_writable(idx) ? 32'd0 : 32'd2);
            if (ref_writable(idx)) model[idx] = ref_merge(model[idx], d, strb);
         end else begin
            axi_read({idx, 2'($urandom_range(0, 3))}, int'($urandom_range(0, 2)), d, r);
            ref_read(idx, ed, er);
            chk("rand_rdata", d, ed);
            chk("rand_rresp", 32'(r), 32'(er));
         end
         chk("rand_gpio", 32'(gpio_out), 32'(model[0][7:0]));
      end

`ifdef AXIL_TIMER_EN
      axi_write(4'h0, 32'h0, 4'hF, 1, r);
      axi_write(4'hC, 32'hFFFF_FFFE, 4'hF, 1, r);
      chk("timer_bresp", 32'(r), 32'd0);
      axi_write(4'h0, 32'h100, 4'hF, 1, r);
      chk1("irq_before_wrap", irq, 1'b0);
      @(negedge sys_clock);
      chk1("irq_after_wrap", irq, 1'b1);
      repeat (3) @(negedge sys_clock);
      chk1("irq_sticky", irq, 1'b1);
      axi_write(4'hC, 32'h0, 4'hF, 1, r);
      chk1("irq_cleared", irq, 1'b0);
      axi_write(4'h0, 32'h0, 4'hF, 1, r);
      model[0] = 32'h0;
`else
      axi_read(4'hC, 0, d, r);
      chk("timer_off_rresp", 32'(r), 32'd2);
      chk("timer_off_rdata", d, 32'd0);
      axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, 1, r);
      chk("timer_off_bresp", 32'(r), 32'd2);
      axi_write(4'h0, 32'h100, 4'hF, 1, r);
      model[0] = 32'h100;
      repeat (5) @(negedge sys_clock);
      chk1("timer_off_irq", irq, 1'b0);
`endif

      // Reset while a B response is pending and unaccepted.
      axi_write(4'h0, 32'h77, 4'hF, 0, r);
      chk("pre_reset_gpio", 32'(gpio_out), 32'h77);
      #2 reset_rtl = 1;
      #1;
      chk1("async_rst_bvalid", s_bvalid, 1'b0);
      chk("async_rst_gpio", 32'(gpio_out), 32'd0);
      chk1("async_rst_irq", irq, 1'b0);
      @(negedge sys_clock);
      reset_rtl = 0;
      s_bready = 0;
      model[0] = '0; model[2] = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge sys_clock);
         chk1("no_b_after_reset", s_bvalid, 1'b0);
      end
      axi_read(4'h0, 0, d, r);
      chk("ctrl_after_reset", d, 32'd0);
      axi_read(4'h8, 0, d, r);
      chk("scratch_after_reset", d, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axil_reg_responder.md
AXIL_REG_RESPONDER -- requirements
Module: axil_reg_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 SHALL have port sys_clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_rtl  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports s_awaddr in ADDR_W, s_awvalid in 1, s_awready out 1: write address channel.
REQ-006 SHALL have ports s_wdata in 32, s_wstrb in 4, s_wvalid in 1, s_wready out 1: write data channel.
REQ-007 SHALL have ports s_bresp out 2, s_bvalid out 1, s_bready in 1: write response channel.
REQ-008 SHALL have ports s_araddr in ADDR_W, s_arvalid in 1, s_arready out 1: read address channel.
REQ-009 SHALL have ports s_rdata out 32, s_rresp out 2, s_rvalid out 1, s_rready in 1: read data channel.
REQ-010 SHALL have ports gpio_out out 8 (CTRL[7:0]) and irq out 1 (timer wrap flag).

Function
REQ-011 SHALL act as an AXI4-Lite responder to the system initiator; only address bits [3:2] are decoded.
- 0x0 CTRL: RW.
- 0x4 ID: RO, value 0x0000_00A5.
- 0x8 SCRATCH: RW.
- 0xC TIMER: see Configuration.
REQ-012 Write FSM SHALL have states W_IDLE and W_RESP.
REQ-013 In W_IDLE, s_awready and s_wready SHALL both be high only when s_awvalid and s_wvalid are both high; the handshake completes in that cycle.
REQ-014 On the handshake, the register SHALL update on the same edge, byte-lane masked by s_wstrb, and the FSM SHALL enter W_RESP with s_bvalid=1 on the next cycle.
REQ-015 W_RESP SHALL hold s_bvalid and s_bresp stable until s_bready=1, then return to W_IDLE; at most one write SHALL be outstanding.
REQ-016 Read FSM SHALL have states R_IDLE and R_DATA; s_arready=1 only in R_IDLE.
REQ-017 On the AR handshake, s_rdata and s_rresp SHALL be registered, with s_rvalid=1 the next cycle (latency 1), held stable until s_rready=1.
REQ-018 Writes to ID, or to any unmapped or disabled address, SHALL have no effect and return s_bresp=2'b10 (SLVERR); all mapped accesses return 2'b00.
REQ-019 Reads of an unmapped or disabled address SHALL return s_rdata=0 and s_rresp=2'b10.
REQ-020 A read and a write in the same cycle to the same register SHALL both proceed; the read returns the pre-write value.
REQ-021 The read and write FSMs SHALL be independent; neither stalls the other.

Reset
REQ-022 While reset_rtl=1, SHALL force:
- FSMs to IDLE;
- all *ready and *valid outputs to 0;
- s_bresp, s_rresp, s_rdata to 0;
- CTRL, SCRATCH, TIMER to 0;
- gpio_out to 0 and irq to 0.
REQ-023 Reset asserted mid-transaction SHALL abandon that transaction; no response is issued after release.
REQ-024 Release SHALL be glitch-free; the first handshake may occur on the first edge after reset_rtl falls.

Configuration
REQ-025 Macro AXIL_TIMER_EN SHALL compile the timer in or out.
REQ-026 With AXIL_TIMER_EN defined:
- TIMER (0xC) is a 32-bit counter that increments each cycle while CTRL[8]=1.
- Wrap from 0xFFFF_FFFF to 0 sets sticky irq=1.
- Any write to 0xC loads s_wdata (strobe-masked) and clears irq; a wrap in that same cycle is overridden by the write.
REQ-027 Without AXIL_TIMER_EN, 0xC SHALL be unmapped per REQ-018/019, irq SHALL be tied to 0, and CTRL[8] SHALL be storage only.

Structure
REQ-028 A shared package SHALL hold the register offsets, ID constant 0xA5, the OKAY/SLVERR response encodings, and the W/R FSM state enums.
REQ-029 The timer SHALL be a sub-module axil_wrap_timer (en, load, load_val, count, wrap), instantiated only under AXIL_TIMER_EN.

Verification
REQ-030 Write 0x0000_005A to 0x0 with strb 0xF, bready=1 -> bvalid one cycle after the handshake, bresp=0, gpio_out=0x5A.
REQ-031 Read 0x4 -> rvalid one cycle after the AR handshake, rdata=0x0000_00A5, rresp=0; rready held low 5 cycles -> rdata/rvalid stable throughout.
REQ-032 Write 0x1234_5678 to 0x8 with strb 0x3 after SCRATCH=0xFFFF_FFFF -> read back 0xFFFF_5678; write to 0x4 -> bresp=2'b10, ID unchanged.
REQ-033 (AXIL_TIMER_EN) Write 0xFFFF_FFFE to 0xC, then CTRL=0x100 -> irq=1 two count cycles later; write 0 to 0xC -> irq=0. Without macro -> read of 0xC gives rresp=2'b10, irq stays 0.
REQ-034 Assert reset_rtl with bvalid=1 and bready=0 -> bvalid=0 asynchronously, gpio_out=0, and no B response after release.
